// File: rtl/paridade_stream.sv
// rtl/paridade_stream.sv - frame parity generator/checker with valid/ready handshakes
module paridade_stream #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             odd_sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_par,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_par,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             clr_err,
  output logic             busy
);

  localparam int IW = $clog2(FRAME_LEN) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t        state;
  logic          acc;
  logic [IW-1:0] idx;
  logic          mode_l;
  logic          odd_l;

  logic word_par;
  logic in_fire;
  logic out_fire;
  logic first_word;
  logic last_word;
  logic acc_base;
  logic eff_mode;
  logic eff_odd;
  logic frame_par;

  // The first word of a frame uses the live mode/odd_sel; later words use the latched copies
  assign word_par   = ^in_data;
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign first_word = (state == IDLE);
  assign last_word  = first_word ? (FRAME_LEN == 1) : (idx == LAST_IDX);
  assign acc_base   = first_word ? 1'b0 : acc;
  assign eff_mode   = first_word ? mode : mode_l;
  assign eff_odd    = first_word ? odd_sel : odd_l;
  assign frame_par  = acc_base ^ word_par ^ eff_odd;
  assign busy       = (state != IDLE);

  // Frame FSM: accumulate word parities, then hold the registered result until consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= 1'b0;
      idx       <= '0;
      mode_l    <= 1'b0;
      odd_l     <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_par   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        EMIT: begin
          if (out_fire) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          in_ready <= 1'b1;
          if (in_fire) begin
            acc <= acc_base ^ word_par;
            if (first_word) begin
              mode_l <= mode;
              odd_l  <= odd_sel;
            end
            if (last_word) begin
              state     <= EMIT;
              idx       <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_par   <= frame_par;
              out_err   <= eff_mode & (in_par != frame_par);
            end else begin
              state <= ACCUM;
              idx   <= idx + IW'(1);
            end
          end
        end
      endcase
    end
  end

  // Saturating error counter; a clear request overrides a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (clr_err) begin
      err_cnt <= '0;
    end else if (out_fire && out_err && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_paridade_stream.sv
// tb/tb_paridade_stream.sv - randomized self-checking bench for paridade_stream
module tb_paridade_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic       odd_sel;
  logic [7:0] in_data;
  logic       in_par;
  logic       clr_err;
  logic       in_valid_a, in_valid_b;
  logic       out_ready_a, out_ready_b;

  logic       in_ready_a, out_valid_a, out_par_a, out_err_a, busy_a;
  logic [1:0] err_cnt_a;
  logic       in_ready_b, out_valid_b, out_par_b, out_err_b, busy_b;
  logic [7:0] err_cnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  paridade_stream #(.WIDTH(8), .FRAME_LEN(4), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .mode(mode), .odd_sel(odd_sel),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data), .in_par(in_par),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_par(out_par_a), .out_err(out_err_a),
    .err_cnt(err_cnt_a), .clr_err(clr_err), .busy(busy_a)
  );

  paridade_stream #(.WIDTH(8), .FRAME_LEN(1), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .mode(mode), .odd_sel(odd_sel),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data), .in_par(in_par),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_par(out_par_b), .out_err(out_err_b),
    .err_cnt(err_cnt_b), .clr_err(clr_err), .busy(busy_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: per DUT, count words and ones in the frame, result = ones mod 2
  int   m_cnt[2], m_ones[2], m_ec[2];
  logic m_valid[2], m_ready[2], m_par[2], m_err[2], m_mode[2], m_odd[2];

  always @(posedge clk or posedge rst) begin : mdl
    int fl, mx, c, o, ec;
    logic v, p, e, md, od, iv, ordy;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_cnt[k] <= 0; m_ones[k] <= 0; m_ec[k] <= 0;
        m_valid[k] <= 1'b0; m_ready[k] <= 1'b0; m_par[k] <= 1'b0;
        m_err[k] <= 1'b0; m_mode[k] <= 1'b0; m_odd[k] <= 1'b0;
      end else begin
        fl = (k == 0) ? 4 : 1;
        mx = (k == 0) ? 3 : 255;
        iv = (k == 0) ? in_valid_a : in_valid_b;
        ordy = (k == 0) ? out_ready_a : out_ready_b;
        c = m_cnt[k]; o = m_ones[k]; ec = m_ec[k];
        v = m_valid[k]; p = m_par[k]; e = m_err[k]; md = m_mode[k]; od = m_odd[k];
        if (v) begin
          if (ordy) begin
            if (e) ec = (ec >= mx) ? mx : ec + 1;
            v = 1'b0;
          end
        end else if (iv && m_ready[k]) begin
          if (c == 0) begin
            md = mode;
            od = odd_sel;
          end
          o = o + $countones(in_data);
          c = c + 1;
          if (c == fl) begin
            p = 1'((o % 2) != 0) ^ od;
            e = md && (in_par != p);
            v = 1'b1;
            c = 0;
            o = 0;
          end
        end
        if (clr_err) ec = 0;
        m_cnt[k] <= c; m_ones[k] <= o; m_ec[k] <= ec;
        m_valid[k] <= v; m_ready[k] <= !v; m_par[k] <= p; m_err[k] <= e;
        m_mode[k] <= md; m_odd[k] <= od;
      end
    end
  end

  // Compare every DUT output against the model each cycle, away from the active edge
  always @(negedge clk) begin
    chk("a.in_ready", in_ready_a, m_ready[0]);
    chk("a.out_valid", out_valid_a, m_valid[0]);
    chk("a.out_par", out_par_a, m_par[0]);
    chk("a.out_err", out_err_a, m_err[0]);
    chk("a.err_cnt", err_cnt_a, m_ec[0]);
    chk("a.busy", busy_a, (m_cnt[0] != 0) || m_valid[0]);
    chk("b.in_ready", in_ready_b, m_ready[1]);
    chk("b.out_valid", out_valid_b, m_valid[1]);
    chk("b.out_par", out_par_b, m_par[1]);
    chk("b.out_err", out_err_b, m_err[1]);
    chk("b.err_cnt", err_cnt_b, m_ec[1]);
    chk("b.busy", busy_b, (m_cnt[1] != 0) || m_valid[1]);
  end

  task automatic put(input int s, input logic [7:0] d, input logic p, input logic md, input logic od);
    int n;
    n = 0;
    in_data = d; in_par = p; mode = md; odd_sel = od;
    if (s == 0) in_valid_a = 1'b1; else in_valid_b = 1'b1;
    while ((((s == 0) ? in_ready_a : in_ready_b) != 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("put_timeout", 0, 1);
    @(negedge clk);
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
  endtask

  task automatic take(input int s, input int hold, input logic clr);
    int n;
    n = 0;
    while ((((s == 0) ? out_valid_a : out_valid_b) != 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("take_timeout", 0, 1);
    repeat (hold) @(negedge clk);
    if (s == 0) out_ready_a = 1'b1; else out_ready_b = 1'b1;
    clr_err = clr;
    @(negedge clk);
    out_ready_a = 1'b0;
    out_ready_b = 1'b0;
    clr_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sat_exp[5];
    int s;
    sat_exp = '{1, 2, 3, 3, 3};
    rst = 1'b1; mode = 1'b0; odd_sel = 1'b0; in_data = 8'h00; in_par = 1'b0; clr_err = 1'b0;
    in_valid_a = 1'b0; in_valid_b = 1'b0; out_ready_a = 1'b0; out_ready_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.in_ready", in_ready_a, 0);
    chk("rst.out_valid", out_valid_a, 0);
    chk("rst.err_cnt", err_cnt_a, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst.in_ready", in_ready_a, 1);

    // Generate even: 1+2+0+8 ones -> odd count -> parity bit 1, valid one cycle after last word
    put(0, 8'h01, 0, 0, 0); put(0, 8'h03, 0, 0, 0); put(0, 8'h00, 0, 0, 0); put(0, 8'hFF, 0, 0, 0);
    chk("t1.out_valid", out_valid_a, 1);
    chk("t1.out_par", out_par_a, 1);
    chk("t1.out_err", out_err_a, 0);
    take(0, 0, 0);
    chk("t1.err_cnt", err_cnt_a, 0);

    // Odd latched at first word, toggled mid-frame
    put(0, 8'h01, 0, 0, 1); put(0, 8'h03, 0, 0, 1); put(0, 8'h00, 0, 0, 0); put(0, 8'hFF, 0, 0, 0);
    chk("t2.out_par", out_par_a, 0);
    take(0, 0, 0);

    // Check mode: 16 ones -> parity 0; received 1 -> error
    put(0, 8'h0F, 0, 1, 0); put(0, 8'h0F, 0, 1, 0); put(0, 8'h0F, 0, 1, 0); put(0, 8'h0F, 1, 1, 0);
    chk("t3.out_par", out_par_a, 0);
    chk("t3.out_err", out_err_a, 1);
    take(0, 0, 0);
    chk("t3.err_cnt", err_cnt_a, 1);
    put(0, 8'h0F, 1, 1, 0); put(0, 8'h0F, 1, 1, 0); put(0, 8'h0F, 1, 1, 0); put(0, 8'h0F, 0, 1, 0);
    chk("t3b.out_err", out_err_a, 0);
    take(0, 0, 0);
    chk("t3b.err_cnt", err_cnt_a, 1);

    // Gaps between words, then output backpressure with a word offered in EMIT
    put(0, 8'h01, 0, 0, 0); repeat (2) @(negedge clk);
    put(0, 8'h03, 0, 0, 0); repeat (2) @(negedge clk);
    put(0, 8'h00, 0, 0, 0); repeat (2) @(negedge clk);
    put(0, 8'hFF, 0, 0, 0);
    chk("t4.out_par", out_par_a, 1);
    in_valid_a = 1'b1; in_data = 8'hAA;
    take(0, 5, 0);
    in_valid_a = 1'b0;
    chk("t4.busy_after", busy_a, 0);
    put(0, 8'h80, 0, 0, 1); put(0, 8'h00, 0, 0, 0); put(0, 8'h00, 0, 0, 0); put(0, 8'h00, 0, 0, 0);
    chk("t4.next_par", out_par_a, 0);
    take(0, 0, 0);

    // Saturation of the 2-bit counter, then clear racing an increment
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    chk("t5.cleared", err_cnt_a, 0);
    for (int j = 0; j < 5; j++) begin
      put(0, 8'h0F, 0, 1, 0); put(0, 8'h0F, 0, 1, 0); put(0, 8'h0F, 0, 1, 0); put(0, 8'h0F, 1, 1, 0);
      take(0, 0, 0);
      chk("t5.sat", err_cnt_a, sat_exp[j]);
    end
    put(0, 8'h0F, 0, 1, 0); put(0, 8'h0F, 0, 1, 0); put(0, 8'h0F, 0, 1, 0); put(0, 8'h0F, 1, 1, 0);
    take(0, 0, 1);
    chk("t5.clr_wins", err_cnt_a, 0);

    // Asynchronous reset in the middle of a frame
    put(0, 8'h01, 0, 0, 0); put(0, 8'h03, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("t6.busy", busy_a, 0);
    chk("t6.in_ready", in_ready_a, 0);
    chk("t6.out_valid", out_valid_a, 0);
    #4 rst = 1'b0;
    @(negedge clk);
    put(0, 8'h80, 0, 0, 0); put(0, 8'h00, 0, 0, 0); put(0, 8'h00, 0, 0, 0); put(0, 8'h00, 0, 0, 0);
    chk("t6.out_par", out_par_a, 1);
    take(0, 0, 0);

    // Single-word frames
    put(1, 8'h07, 0, 0, 0);
    chk("t7.out_valid", out_valid_b, 1);
    chk("t7.out_par", out_par_b, 1);
    take(1, 0, 0);

    // Randomized frames on both instances
    for (int i = 0; i < 60; i++) begin
      s = int'($urandom_range(0, 1));
      for (int w = 0; w < ((s == 0) ? 4 : 1); w++) begin
        put(s, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      take(s, int'($urandom_range(0, 3)), 1'($urandom_range(0, 7) == 0));
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
